mem_arbiter: RTL and testbench

- Shares one single-ported unified memory bus between the instruction-fetch port (IF) and the data port (MEM stage) of the 5-stage MIPS pipeline.
- Generates rom_stall / ram_stall for the pipeline controller, which freezes IF/ID and bubbles EXE while either is high.
- Data requests take priority, and both requests are served within one pipeline freeze.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arb_ibuf.sv | 56 +++++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : mem_arbiter_pkg                                    |
// | Description : Shared types for the unified-memory bus arbiter.   |
// |               Holds the arbiter FSM state encoding.              |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package mem_arbiter_pkg;

  // Arbiter FSM encoding; values are fixed so the bus state can be
  // decoded directly from waveforms.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_ibuf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mem_arb_ibuf                                       |
// | Description : One-entry instruction fetch buffer for the memory  |
// |               arbiter. Filled by every completed fetch, looked   |
// |               up combinationally, dropped when a store hits the  |
// |               buffered word.                                     |
// | Ports       : clk, rst_n      clock, async active-low reset      |
// |               lookup_cs/addr  current fetch request              |
// |               fill/_addr/_data completed bus fetch               |
// |               inv/inv_word    completed store, word address      |
// |               hit/hit_data    lookup result                      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module mem_arb_ibuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_cs,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  inv,
  input  logic [ADDR_WIDTH-3:0] inv_word,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data
);

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  // Fill and invalidate come from different bus states, so they are
  // never active in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (fill) begin
      r_valid <= 1'b1;
      r_addr  <= fill_addr;
      r_data  <= fill_data;
    end else if (inv && (r_addr[ADDR_WIDTH-1:2] == inv_word)) begin
      r_valid <= 1'b0;
    end
  end

  assign hit      = lookup_cs & r_valid & (lookup_addr == r_addr);
  assign hit_data = r_data;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mem_arbiter                                        |
// | Description : Shares one single-ported memory bus between the    |
// |               instruction fetch port (rom_*) and the data port   |
// |               (ram_*). Data requests win; both requests of one   |
// |               pipeline freeze are served before the stalls drop. |
// | Ports       : clk, rst_n       clock, async active-low reset     |
// |               rom_*            fetch request / result / stall    |
// |               ram_*            data request / result / stall     |
// |               mem_*            registered shared bus, mem_ack    |
// | Options     : MEM_ARB_IBUF_EN  adds a one-entry fetch buffer     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rom_cs,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  rom_stall,
  input  logic                  ram_cs,
  input  logic                  ram_we,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_stall,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  r_rom_done;
  logic                  r_ram_done;
  logic [DATA_WIDTH-1:0] r_rom_dout;
  logic [DATA_WIDTH-1:0] r_ram_dout;
  logic                  r_mem_cs;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  w_rom_hit;
  logic                  w_advance;
  logic                  w_ack_d;
  logic                  w_ack_i;
  logic                  w_start_d;
  logic                  w_start_i;

  // An ack only counts while a bus access is outstanding; acks seen in
  // IDLE are ignored.
  assign w_ack_d = (r_state == BUS_D) & mem_ack;
  assign w_ack_i = (r_state == BUS_I) & mem_ack;

`ifdef MEM_ARB_IBUF_EN
  logic [DATA_WIDTH-1:0] w_ibuf_data;

  mem_arb_ibuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ibuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_cs   (rom_cs),
    .lookup_addr (rom_addr),
    .fill        (w_ack_i),
    .fill_addr   (r_mem_addr),
    .fill_data   (mem_rdata),
    .inv         (w_ack_d & r_mem_we),
    .inv_word    (r_mem_addr[ADDR_WIDTH-1:2]),
    .hit         (w_rom_hit),
    .hit_data    (w_ibuf_data)
  );

  // A fetch already completed over the bus keeps its own result; the
  // buffer only supplies data for fetches that skipped the bus.
  assign rom_dout = (r_rom_done | ~w_rom_hit) ? r_rom_dout : w_ibuf_data;
`else
  assign w_rom_hit = 1'b0;
  assign rom_dout  = r_rom_dout;
`endif

  assign rom_stall = rom_cs & ~r_rom_done & ~w_rom_hit;
  assign ram_stall = ram_cs & ~r_ram_done;
  assign w_advance = ~rom_stall & ~ram_stall;

  assign ram_dout  = r_ram_dout;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Next-state decode. Starting from the stall terms (not the raw done
  // flags) keeps a buffered fetch hit from launching a bus access, and
  // makes the advance cycle a dead cycle automatically.
  always_comb begin
    w_state_nxt = r_state;
    w_start_d   = 1'b0;
    w_start_i   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ram_stall) begin
          w_state_nxt = BUS_D;
          w_start_d   = 1'b1;
        end else if (rom_stall) begin
          w_state_nxt = BUS_I;
          w_start_i   = 1'b1;
        end
      end
      BUS_D, BUS_I: begin
        if (mem_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rom_dout  <= '0;
      r_ram_dout  <= '0;
      r_rom_done  <= 1'b0;
      r_ram_done  <= 1'b0;
    end else begin
      // Bus request is launched from the IDLE decision and held until ack.
      if (w_start_d) begin
        r_mem_cs    <= 1'b1;
        r_mem_we    <= ram_we;
        r_mem_addr  <= ram_addr;
        r_mem_wdata <= ram_din;
      end else if (w_start_i) begin
        r_mem_cs    <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= rom_addr;
      end else if (w_ack_d | w_ack_i) begin
        r_mem_cs    <= 1'b0;
      end

      // A requester that dropped cs (flush) gets its result discarded.
      if (w_ack_d & ram_cs & ~r_mem_we) begin
        r_ram_dout <= mem_rdata;
      end
      if (w_ack_i & rom_cs) begin
        r_rom_dout <= mem_rdata;
      end

      // Clearing on advance has priority so a flushed access can never
      // leave a stale done flag that would let the next request through.
      if (w_advance) begin
        r_rom_done <= 1'b0;
        r_ram_done <= 1'b0;
      end else begin
        if (w_ack_d & ram_cs) begin
          r_ram_done <= 1'b1;
        end
        if (w_ack_i & rom_cs) begin
          r_rom_done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                     |
// | Description : Self-checking bench for mem_arbiter. A behavioural |
// |               memory answers bus accesses after chosen delays;   |
// |               a transaction-level model predicts bus order,      |
// |               stall lengths and returned data.                   |
// | Options     : MEM_ARB_IBUF_EN  models the fetch buffer too       |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_cs, ram_cs, ram_we, mem_ack;
  logic [31:0] rom_addr, ram_addr, ram_din, mem_rdata;
  logic [31:0] rom_dout, ram_dout, mem_addr, mem_wdata;
  logic        rom_stall, ram_stall, mem_cs, mem_we;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .rom_stall (rom_stall),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_stall (ram_stall),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
  } acc_t;

  int          total = 0;
  int          bad   = 0;
  acc_t        exp_q[$];
  logic [31:0] mem_env [logic [31:0]];
  logic [31:0] mem_ref [logic [31:0]];
  logic [31:0] last_ram;
  bit          ram_known;
  bit          ib_valid;
  logic [31:0] ib_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C01, ~a[15:0]};
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    if (mem_env.exists(a)) return mem_env[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (mem_ref.exists(a)) return mem_ref[a];
    return init_word(a);
  endfunction

  // One pipeline step: requests applied in cycle 0, run until the
  // pipeline may advance (or, for a flush, until the bus goes quiet).
  task automatic run_txn(input bit rq_d, input bit we, input logic [31:0] ra,
                         input logic [31:0] wd, input bit rq_i, input logic [31:0] ia,
                         input bit flush, input int dd, input int di);
    logic [31:0] exp_ram, exp_rom;
    bit          hit0, hit1, need_i, busy, fin;
    int          ram_hi, rom_hi, cnt_ram, cnt_rom, cnt;
    acc_t        cur;

    // Reference: data access first, then the fetch if it still needs the bus.
    exp_ram = '0;
    hit0    = 1'b0;
`ifdef MEM_ARB_IBUF_EN
    hit0 = rq_i && ib_valid && (ib_addr == ia);
`endif
    if (rq_d) begin
      exp_q.push_back('{we, ra, wd, dd});
      if (we) begin
        mem_ref[ra] = wd;
`ifdef MEM_ARB_IBUF_EN
        if (ib_valid && (ib_addr[31:2] == ra[31:2])) ib_valid = 1'b0;
`endif
      end else begin
        exp_ram = ref_rd(ra);
      end
    end
    hit1 = 1'b0;
`ifdef MEM_ARB_IBUF_EN
    hit1 = rq_i && ib_valid && (ib_addr == ia);
`endif
    need_i  = rq_i && !hit1;
    exp_rom = ref_rd(ia);
    if (need_i) begin
      exp_q.push_back('{1'b0, ia, 32'h0, di});
      ib_valid = 1'b1;
      ib_addr  = ia;
    end
    // Each bus access costs one decision cycle plus (delay+1) bus cycles.
    ram_hi = rq_d ? (flush ? 2 : dd + 2) : 0;
    rom_hi = need_i ? (di + 2) + ((rq_d && !hit0) ? dd + 2 : 0) : 0;

    @(posedge clk); #1;
    mem_ack  = 1'b0;
    ram_cs   = rq_d;
    ram_we   = we;
    ram_addr = ra;
    ram_din  = wd;
    rom_cs   = rq_i;
    rom_addr = ia;
    // Stray ack in the IDLE decision cycle must be ignored.
    if ($urandom_range(0, 3) == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end

    busy = 1'b0; fin = 1'b0; cnt = 0; cnt_ram = 0; cnt_rom = 0;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (flush && cyc == 2) ram_cs = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) check_eq("idle_mem_cs", mem_cs, 1'b0);
      if (mem_cs && !busy) begin
        check_eq("pending_access", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur  = exp_q.pop_front();
          busy = 1'b1;
          cnt  = cur.dly;
        end
      end
      if (busy) begin
        check_eq("bus_cs", mem_cs, 1'b1);
        check_eq("bus_addr", mem_addr, cur.addr);
        check_eq("bus_we", mem_we, cur.we);
        if (cur.we) check_eq("bus_wdata", mem_wdata, cur.wdata);
        if (cnt == 0) begin
          mem_ack = 1'b1;
          if (cur.we) begin
            mem_env[cur.addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = env_rd(cur.addr);
          end
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (ram_stall) cnt_ram++;
      if (rom_stall) cnt_rom++;
      if (!ram_stall && !rom_stall && (!flush || (!busy && exp_q.size() == 0)))
        fin = 1'b1;
    end

    check_eq("txn_done", fin, 1'b1);
    check_eq("ram_stall_cycles", cnt_ram, ram_hi);
    check_eq("rom_stall_cycles", cnt_rom, rom_hi);
    check_eq("unserved_accesses", exp_q.size(), 0);
    if (!flush) begin
      if (rq_d && !we) begin
        check_eq("ram_dout_load", ram_dout, exp_ram);
        last_ram  = exp_ram;
        ram_known = 1'b1;
      end
      if (rq_d && we && ram_known) check_eq("ram_dout_store_hold", ram_dout, last_ram);
      if (rq_i) check_eq("rom_dout", rom_dout, exp_rom);
    end else begin
      ram_known = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic reset_midaccess();
    @(posedge clk); #1;
    mem_ack  = 1'b0;
    ram_cs   = 1'b1;
    ram_we   = 1'b0;
    ram_addr = 32'h2008;
    rom_cs   = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pre_mem_cs", mem_cs, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_mem_cs", mem_cs, 1'b0);
    check_eq("rst_ram_stall_follows_cs", ram_stall, 1'b1);
    check_eq("rst_ram_dout", ram_dout, 32'h0);
    ram_cs = 1'b0;
    #1 check_eq("rst_ram_stall_low", ram_stall, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    ib_valid  = 1'b0;
    last_ram  = '0;
    ram_known = 1'b1;
    @(negedge clk);
    check_eq("rst_post_mem_cs", mem_cs, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rq_d, rq_i, we, fl;
    logic [31:0] ra, ia, wd;
    int          k;

    rst_n = 1'b0; rom_cs = 1'b0; ram_cs = 1'b0; ram_we = 1'b0; mem_ack = 1'b0;
    rom_addr = '0; ram_addr = '0; ram_din = '0; mem_rdata = '0;
    ib_valid = 1'b0; ib_addr = '0; last_ram = '0; ram_known = 1'b1;
    mem_env[32'h100] = 32'h3C010001;
    mem_ref[32'h100] = 32'h3C010001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_mem_cs", mem_cs, 1'b0);
    check_eq("reset_mem_we", mem_we, 1'b0);
    check_eq("reset_mem_addr", mem_addr, 32'h0);
    check_eq("reset_mem_wdata", mem_wdata, 32'h0);
    check_eq("reset_rom_dout", rom_dout, 32'h0);
    check_eq("reset_ram_dout", ram_dout, 32'h0);
    check_eq("reset_rom_stall", rom_stall, 1'b0);
    check_eq("reset_ram_stall", ram_stall, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fetch 0x100, ack one cycle after mem_cs rises: 3 stall cycles.
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0, 0, 1);
    // Load + fetch together, immediate acks: D then I, both low at cycle 4.
    run_txn(1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h104, 1'b0, 0, 0);
    // Store held on the bus for a slow ack; ram_dout keeps the last load.
    run_txn(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, 0);
    run_txn(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 32'h0, 1'b0, 1, 0);
    // Asynchronous reset in the middle of a data access.
    reset_midaccess();
    // Refetch, then store into the fetched word and refetch again.
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b0, 0, 0);
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b0, 0, 2);
    run_txn(1'b1, 1'b1, 32'h104, 32'h12345678, 1'b0, 32'h0, 1'b0, 0, 0);
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b0, 0, 1);
    // Flush of an in-flight load, followed by a normal load.
    run_txn(1'b1, 1'b0, 32'h2004, 32'h0, 1'b0, 32'h0, 1'b1, 2, 0);
    run_txn(1'b1, 1'b0, 32'h2004, 32'h0, 1'b0, 32'h0, 1'b0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 9);
      ia = 32'h100 + (32'($urandom_range(0, 5)) << 2);
      ra = ($urandom_range(0, 1) == 0) ? (32'h100 + (32'($urandom_range(0, 5)) << 2))
                                        : (32'h2000 + (32'($urandom_range(0, 3)) << 2));
      wd = $urandom;
      fl = (k == 0);
      if (fl) begin
        run_txn(1'b1, 1'b0, ra, wd, 1'b0, ia, 1'b1, $urandom_range(1, 3), 0);
      end else begin
        rq_d = $urandom_range(0, 1) == 1;
        rq_i = $urandom_range(0, 2) != 0;
        we   = $urandom_range(0, 1) == 1;
        run_txn(rq_d, we, ra, wd, rq_i, ia, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    @(posedge clk); #1;
    rom_cs = 1'b0; ram_cs = 1'b0; mem_ack = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
